// File: rtl/aes_pipe_seq_ctrl.sv
// AES pipeline sequencing controller: admits requests, launches them into the
// fixed-latency datapath, and tracks completions, abort flush and zeroize.
module aes_pipe_seq_ctrl #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned LAT128       = 22,
  parameter int unsigned LAT192       = 26,
  parameter int unsigned LAT256       = 30
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [1:0]                            in_mode,
  input  logic [TAG_W-1:0]                      in_tag,
  output logic                                  issue,
  output logic [1:0]                            issue_mode,
  input  logic                                  abort,
  output logic                                  out_valid,
  output logic [TAG_W-1:0]                      out_tag,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  err_illegal,
  output logic                                  zeroize
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned IDX_W = (LAT256 > 2) ? $clog2(LAT256) : 1;

  // slot[i] in cycle c holds the operation whose out_valid is due in cycle c+1+i
  logic [LAT256-1:0] slot_vld;
  logic [LAT256-1:0] slot_vld_nx;
  logic [TAG_W-1:0]  slot_tag    [LAT256];
  logic [TAG_W-1:0]  slot_tag_nx [LAT256];

  logic              abort_q;
  logic              legal_c;
  logic [IDX_W-1:0]  chk_idx_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic              slot_free_c;
  logic              cap_ok_c;
  logic              accept_c;
  logic              accept_legal_c;

  logic              issue_nx;
  logic [1:0]        issue_mode_nx;
  logic              out_valid_nx;
  logic [TAG_W-1:0]  out_tag_nx;
  logic [CNT_W-1:0]  inflight_nx;
  logic              err_illegal_nx;
  logic              zeroize_nx;

  // Latency decode: slot to probe now, and where it lands after this cycle's shift
  always_comb begin
    legal_c   = 1'b1;
    chk_idx_c = IDX_W'(LAT128 - 1);
    wr_idx_c  = IDX_W'(LAT128 - 2);
    case (in_mode)
      2'b01: begin
        chk_idx_c = IDX_W'(LAT192 - 1);
        wr_idx_c  = IDX_W'(LAT192 - 2);
      end
      2'b10: begin
        chk_idx_c = IDX_W'(LAT256 - 1);
        wr_idx_c  = IDX_W'(LAT256 - 2);
      end
      2'b11: legal_c = 1'b0;
      default: ;
    endcase
  end

  // A completion this cycle frees a credit, so a full pipe can still accept
  assign slot_free_c    = !legal_c || !slot_vld[chk_idx_c];
  assign cap_ok_c       = (inflight < CNT_W'(MAX_INFLIGHT)) || out_valid;
  assign in_ready       = !rst && !abort && cap_ok_c && slot_free_c;
  assign accept_c       = in_valid && in_ready;
  assign accept_legal_c = accept_c && legal_c;

  // Next-state for the slot pipe and all registered outputs
  always_comb begin
    slot_vld_nx = {1'b0, slot_vld[LAT256-1:1]};
    for (int unsigned i = 0; i < LAT256 - 1; i++) begin
      slot_tag_nx[i] = slot_tag[i+1];
    end
    slot_tag_nx[LAT256-1] = '0;
    if (accept_legal_c) begin
      slot_vld_nx[wr_idx_c] = 1'b1;
      slot_tag_nx[wr_idx_c] = in_tag;
    end
    if (abort) begin
      slot_vld_nx = '0;
    end

    issue_nx       = accept_legal_c;
    issue_mode_nx  = accept_legal_c ? in_mode : 2'b00;
    err_illegal_nx = accept_c && !legal_c;

    // A completion already on out_valid during abort is let through; later ones are dropped
    out_valid_nx = !abort && slot_vld[0];
    out_tag_nx   = out_valid_nx ? slot_tag[0] : '0;

    if (abort) begin
      inflight_nx = '0;
    end else if (accept_legal_c && !out_valid) begin
      inflight_nx = inflight + CNT_W'(1);
    end else if (!accept_legal_c && out_valid) begin
      inflight_nx = inflight - CNT_W'(1);
    end else begin
      inflight_nx = inflight;
    end

    zeroize_nx = (abort && !abort_q) ||
                 (!abort && out_valid && !accept_legal_c && (inflight == CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld    <= '0;
      slot_tag    <= '{default: '0};
      abort_q     <= 1'b0;
      issue       <= 1'b0;
      issue_mode  <= 2'b00;
      out_valid   <= 1'b0;
      out_tag     <= '0;
      inflight    <= '0;
      err_illegal <= 1'b0;
      zeroize     <= 1'b0;
    end else begin
      slot_vld    <= slot_vld_nx;
      slot_tag    <= slot_tag_nx;
      abort_q     <= abort;
      issue       <= issue_nx;
      issue_mode  <= issue_mode_nx;
      out_valid   <= out_valid_nx;
      out_tag     <= out_tag_nx;
      inflight    <= inflight_nx;
      err_illegal <= err_illegal_nx;
      zeroize     <= zeroize_nx;
    end
  end

endmodule

// File: tb/tb_aes_pipe_seq_ctrl.sv
// Bench for aes_pipe_seq_ctrl: per-cycle scoreboard monitor plus a latency
// vector table and hand-written abort/reset/backpressure sequences.
module tb_aes_pipe_seq_ctrl;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned MAXI  = 8;
  localparam int unsigned CW    = $clog2(MAXI + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             issue;
  logic [1:0]       issue_mode;
  logic             abort;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    inflight;
  logic             err_illegal;
  logic             zeroize;

  aes_pipe_seq_ctrl #(
    .TAG_W(TAG_W), .MAX_INFLIGHT(MAXI), .LAT128(22), .LAT192(26), .LAT256(30)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_tag(in_tag), .issue(issue), .issue_mode(issue_mode),
    .abort(abort), .out_valid(out_valid), .out_tag(out_tag), .inflight(inflight),
    .err_illegal(err_illegal), .zeroize(zeroize)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] m);
    case (m)
      2'b00: return 22;
      2'b01: return 26;
      2'b10: return 30;
      default: return 0;
    endcase
  endfunction

  // Scoreboard: one entry per legal accepted request, keyed by its due cycle
  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
  } ent_t;
  ent_t sb[$];

  logic             prev_legal   = 1'b0;
  logic             prev_illegal = 1'b0;
  logic [1:0]       prev_mode    = 2'b00;
  logic             prev_abort   = 1'b0;
  logic             pend_zero    = 1'b0;

  logic             m_exp_ov;
  logic [TAG_W-1:0] m_due_tag;
  logic             m_legal;
  logic             m_busy;
  logic             m_ready;
  logic             m_acc;
  int               m_lat;
  int               m_size;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due < cyc) sb.delete(i);
      m_exp_ov  = 1'b0;
      m_due_tag = '0;
      m_legal   = (in_mode != 2'b11);
      m_lat     = lat_of(in_mode);
      m_busy    = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].due == cyc) begin
          m_exp_ov  = 1'b1;
          m_due_tag = sb[i].tag;
        end
        if (m_legal && sb[i].due == cyc + m_lat) m_busy = 1'b1;
      end
      m_size  = sb.size();
      m_ready = !rst && !abort && ((m_size < int'(MAXI)) || m_exp_ov) && !m_busy;

      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("out_valid", int'(out_valid), int'(m_exp_ov));
      if (m_exp_ov) chk("out_tag", int'(out_tag), int'(m_due_tag));
      chk("issue", int'(issue), int'(prev_legal));
      if (prev_legal) chk("issue_mode", int'(issue_mode), int'(prev_mode));
      chk("err_illegal", int'(err_illegal), int'(prev_illegal));
      chk("inflight", int'(inflight), m_size);
      chk("zeroize", int'(zeroize), int'(pend_zero));

      m_acc = in_valid && m_ready;
      if (rst) begin
        sb.delete();
        prev_legal   = 1'b0;
        prev_illegal = 1'b0;
        prev_mode    = 2'b00;
        prev_abort   = 1'b0;
        pend_zero    = 1'b0;
      end else begin
        pend_zero = (abort && !prev_abort) ||
                    (!abort && m_exp_ov && m_size == 1 && !(m_acc && m_legal));
        if (abort) begin
          for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
        end
        if (m_acc && m_legal) sb.push_back('{due: cyc + m_lat, tag: in_tag});
        prev_legal   = m_acc && m_legal;
        prev_illegal = m_acc && !m_legal;
        prev_mode    = in_mode;
        prev_abort   = abort;
      end
    end
  end

  // Hold a request until accepted; reports the first drive cycle and accept cycle
  task automatic send(input logic [1:0] m, input logic [TAG_W-1:0] t,
                      output int drv, output int acc);
    acc = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; in_tag = t;
    drv = cyc;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = 2'b00; in_tag = '0;
    if (acc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc >= n) return;
    end
    chk("wait_timeout", cyc, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !pend_zero) break;
    end
    chk("idle_reached", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic count_out(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               err;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int drv, acc, a1, a2, ab, n_acc, cnt, lat, err;

    vecs[0] = '{mode: 2'b00, tag: 4'd5,  lat: 22, err: 0};
    vecs[1] = '{mode: 2'b01, tag: 4'd6,  lat: 26, err: 0};
    vecs[2] = '{mode: 2'b10, tag: 4'd9,  lat: 30, err: 0};
    vecs[3] = '{mode: 2'b11, tag: 4'd3,  lat: -1, err: 1};
    vecs[4] = '{mode: 2'b00, tag: 4'd15, lat: 22, err: 0};
    vecs[5] = '{mode: 2'b10, tag: 4'd0,  lat: 30, err: 0};

    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_tag = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(in_ready), 1);
    chk("inflight_reset", int'(inflight), 0);

    foreach (vecs[v]) begin
      wait_idle();
      send(vecs[v].mode, vecs[v].tag, drv, acc);
      lat = -1; err = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (err_illegal) err = 1;
        if (out_valid && out_tag == vecs[v].tag && lat < 0) lat = cyc - acc;
      end
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("vec%0d_err", v), err, vecs[v].err);
    end

    // Single 192 request: completion, drain to zero, zeroize
    wait_idle();
    send(2'b01, 4'd5, drv, a1);
    @(negedge clk);
    chk("s192_issue", int'(issue), 1);
    chk("s192_issue_mode", int'(issue_mode), 1);
    wait_neg(a1 + 26);
    chk("s192_out_valid", int'(out_valid), 1);
    chk("s192_out_tag", int'(out_tag), 5);
    chk("s192_inflight_pre", int'(inflight), 1);
    wait_neg(a1 + 27);
    chk("s192_zeroize", int'(zeroize), 1);
    chk("s192_inflight_post", int'(inflight), 0);

    // Slot collision: 256 then 128 eight cycles later
    wait_idle();
    send(2'b10, 4'd1, drv, a1);
    wait_neg(a1 + 7);
    send(2'b00, 4'd2, drv, a2);
    chk("coll_drive_cycle", drv - a1, 8);
    chk("coll_accept_cycle", a2 - a1, 9);
    wait_neg(a1 + 30);
    chk("coll_tag1", int'(out_tag), 1);
    wait_neg(a1 + 31);
    chk("coll_tag2", int'(out_tag), 2);

    // Back-to-back 128 requests against the inflight cap
    wait_idle();
    n_acc = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_mode = 2'b00; in_tag = TAG_W'(k);
      @(negedge clk);
      if (in_ready && k < 22) n_acc++;
      if (k == 8)  chk("b2b_ready_k8", int'(in_ready), 0);
      if (k == 21) chk("b2b_ready_k21", int'(in_ready), 0);
      if (k == 22) begin
        chk("b2b_ready_k22", int'(in_ready), 1);
        chk("b2b_first_out", int'(out_valid), 1);
      end
      if (k == 23) chk("b2b_inflight_k23", int'(inflight), 8);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_tag = '0;
    chk("b2b_accepts", n_acc, 8);

    // Illegal mode: error strobe only
    wait_idle();
    send(2'b11, 4'd3, drv, acc);
    chk("ill_err", int'(err_illegal), 1);
    chk("ill_issue", int'(issue), 0);
    chk("ill_inflight", int'(inflight), 0);

    // Abort with four 192 ops in flight, held three cycles
    wait_idle();
    send(2'b01, 4'd8, drv, a1);
    send(2'b01, 4'd9, drv, acc);
    send(2'b01, 4'd10, drv, acc);
    send(2'b01, 4'd11, drv, acc);
    wait_neg(a1 + 14);
    @(posedge clk); #1 abort = 1'b1;
    ab = cyc;
    @(negedge clk);
    chk("abort_inflight_pre", int'(inflight), 4);
    chk("abort_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("abort_inflight_post", int'(inflight), 0);
    chk("abort_zeroize", int'(zeroize), 1);
    chk("abort_cycle", cyc - ab, 1);
    @(negedge clk);
    chk("abort_zeroize_once", int'(zeroize), 0);
    @(posedge clk); #1 abort = 1'b0;
    count_out(40, cnt);
    chk("abort_no_out", cnt, 0);

    // Abort while idle still zeroizes once
    wait_idle();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_zeroize", int'(zeroize), 1);

    // Completion due in the abort cycle still emitted
    wait_idle();
    send(2'b00, 4'd7, drv, a1);
    send(2'b10, 4'd8, drv, acc);
    wait_neg(a1 + 21);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_edge_out", int'(out_valid), 1);
    chk("abort_edge_tag", int'(out_tag), 7);
    @(posedge clk); #1 abort = 1'b0;
    count_out(40, cnt);
    chk("abort_edge_no_more", cnt, 0);

    // Reset mid-operation
    wait_idle();
    send(2'b10, 4'd1, drv, acc);
    send(2'b10, 4'd2, drv, acc);
    send(2'b10, 4'd3, drv, acc);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_tag = 4'd12;
    @(negedge clk);
    chk("rst_accept_first", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_tag = '0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || zeroize) cnt++;
    end
    chk("rst_no_stale", cnt, 0);

    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
